// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified single-port memory bus between the arbiter (master) and the memory (slave).
// Handshake: mEn is held high for the whole access with mAdr/mWe/mWrData stable; the access
// completes on the first rising edge where mEn and mReady are both high (mRdata sampled there).
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              mEn;
    logic              mWe;
    logic [DATA_W-1:0] mAdr;
    logic [DATA_W-1:0] mWrData;
    logic [DATA_W-1:0] mRdata;
    logic              mReady;

    modport master (
        output mEn, mWe, mAdr, mWrData,
        input  mRdata, mReady
    );

    modport slave (
        input  mEn, mWe, mAdr, mWrData,
        output mRdata, mReady
    );
endinterface

// File: rtl/arb_timeout_cnt.sv
// Counts BUSY cycles; expired is high in the LIMIT-th consecutive enabled cycle.
module arb_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(LIMIT - 1))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage requests onto one single-port memory.
// Optional BUSY timeout guarded by macro ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [DATA_W-1:0] ifAdr,
    input  logic              memReq,
    input  logic              memWe,
    input  logic [DATA_W-1:0] memAdr,
    input  logic [DATA_W-1:0] memWrData,
    output logic              ifDone,
    output logic              memDone,
    output logic [DATA_W-1:0] rData,
    output logic              ifStall,
    output logic              memStall,
    output logic              timeoutErr,
    output arbState_t         dbgState,
    mem_port_arbiter_if.master memBus
);
    arbState_t         state, stateNext;
    owner_t            owner;
    logic              busy, grantIf, grantMem, finish, timedOut, expired;
    logic              latWe;
    logic [DATA_W-1:0] latAdr, latWrData;

    assign busy  = (state != IDLE);
    assign owner = (state == BUSY_MEM) ? OWN_MEM : OWN_IF;

    always_comb begin
        stateNext = state;
        grantIf   = 1'b0;
        grantMem  = 1'b0;
        finish    = 1'b0;
        timedOut  = 1'b0;
        case (state)
            // A requester whose done is high this cycle is not re-granted.
            IDLE: begin
                if (memReq && !memDone) begin
                    grantMem  = 1'b1;
                    stateNext = BUSY_MEM;
                end else if (ifReq && !ifDone) begin
                    grantIf   = 1'b1;
                    stateNext = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (memBus.mReady) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end else if (expired) begin
                    finish    = 1'b1;
                    timedOut  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            latWe     <= 1'b0;
            latAdr    <= '0;
            latWrData <= '0;
            rData     <= '0;
            ifDone    <= 1'b0;
            memDone   <= 1'b0;
        end else begin
            state   <= stateNext;
            ifDone  <= finish && (owner == OWN_IF);
            memDone <= finish && (owner == OWN_MEM);
            if (grantMem) begin
                latWe     <= memWe;
                latAdr    <= memAdr;
                latWrData <= memWrData;
            end else if (grantIf) begin
                latWe     <= 1'b0;
                latAdr    <= ifAdr;
                latWrData <= '0;
            end
            // Only a read that really completed refreshes rData.
            if (finish && !timedOut && !latWe) begin
                rData <= memBus.mRdata;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic timeoutErrQ;

    arb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeoutErrQ <= 1'b0;
        end else if (timedOut) begin
            timeoutErrQ <= 1'b1;
        end
    end

    assign timeoutErr = timeoutErrQ;
`else
    assign expired    = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    assign memBus.mEn     = busy;
    assign memBus.mWe     = busy && latWe;
    assign memBus.mAdr    = latAdr;
    assign memBus.mWrData = latWrData;

    assign ifStall  = ifReq && !ifDone;
    assign memStall = memReq && !memDone;
    assign dbgState = state;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, BUSY-cycle limit when ARB_TIMEOUT_EN is defined.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Ports ifReq in 1, ifAdr in DATA_W: fetch read request and address, held until ifDone.
REQ-006 Ports memReq in 1, memWe in 1, memAdr in DATA_W, memWrData in DATA_W: data-stage request, held until memDone.
REQ-007 Ports ifDone out 1, memDone out 1, rData out DATA_W: one-cycle completion pulses and registered read data.
REQ-008 Ports ifStall out 1, memStall out 1: stall indications for the pipeline (feed pcWrite/ifidWrite/stall).
REQ-009 Ports mEn out 1, mWe out 1, mAdr out DATA_W, mWrData out DATA_W, mRdata in DATA_W, mReady in 1: unified single-port memory.
REQ-010 Port timeoutErr out 1: sticky timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM.
REQ-012 In IDLE, memReq SHALL win over ifReq when both are high; loser is not latched.
REQ-013 On grant, the winner's address, write data and write enable SHALL be latched; next state is BUSY_MEM or BUSY_IF.
REQ-014 In a BUSY state, mEn SHALL be 1 and mAdr/mWe/mWrData SHALL drive latched values; in IDLE, mEn=0 and mWe=0.
REQ-015 A BUSY_IF transaction SHALL drive mWe=0 regardless of memWe.
REQ-016 In a BUSY state with mReady=1, the next edge SHALL capture mRdata into rData, pulse the owner's done for exactly one cycle, and return to IDLE.
REQ-017 Minimum latency: req sampled at edge N, mEn high in cycle N+1; if mReady=1 in that cycle, done is high in cycle N+2.
REQ-018 rData SHALL hold its value until the next completed read; writes SHALL NOT update rData.
REQ-019 In the cycle a requester's done is high, its req SHALL be ignored for arbitration; the other requester may be granted in that cycle.
REQ-020 ifStall = ifReq AND NOT ifDone; memStall = memReq AND NOT memDone (combinational).
REQ-021 A requester dropping req while BUSY SHALL NOT abort the transaction; done still pulses.
REQ-022 mReady while IDLE SHALL be ignored.

Reset
REQ-023 rst low SHALL immediately force IDLE, mEn=0, mWe=0, ifDone=0, memDone=0, rData=0, mAdr=0, mWrData=0, timeoutErr=0, counter=0.
REQ-024 A transaction in flight at reset SHALL be discarded without a done pulse.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN defined: counter counts BUSY cycles; on reaching TIMEOUT_CYCLES with mReady still 0, SHALL return to IDLE, pulse owner's done, leave rData unchanged and set timeoutErr until reset.
REQ-026 ARB_TIMEOUT_EN undefined: BUSY waits indefinitely for mReady; timeoutErr tied 0; no counter logic.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the FSM state enum, owner encoding (OWN_IF, OWN_MEM) and default width/timeout constants.
REQ-028 Sub-module arb_timeout_cnt (clear, enable, expired) SHALL be instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-029 ifReq=1, ifAdr=0x40, mReady=1 first BUSY cycle, mRdata=0x8C010004 -> mEn one cycle, ifDone in cycle 2, rData=0x8C010004.
REQ-030 ifReq and memReq (memWe=1, memAdr=0x100, memWrData=0xDEADBEEF) same cycle -> BUSY_MEM first with mWe=1; memDone; then BUSY_IF; ifStall high throughout.
REQ-031 memReq read, mReady delayed 3 cycles -> mEn held 3 cycles, memStall high 4 cycles, memDone one cycle after mReady.
REQ-032 rst low during BUSY_IF -> mEn=0 immediately, no ifDone; after release ifReq re-granted from IDLE.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15, mReady stuck 0 -> done after 15 BUSY cycles, timeoutErr=1 sticky, rData unchanged.
REQ-034 mReady pulsed while IDLE, no requests -> no done, no state change.
